sdm_ratio_modulator: RTL and testbench
======================================

Name: sdm_ratio_modulator

Overview:
- MASH 1-1-1 delta-sigma modulator and ratio encoder feeding the p/e program inputs of the Vaucher 2/3-cell integer divider.
- Clocked by the divider's own output clock, so it produces one new modulus per divider output period.
- The time-averaged division ratio equals n_int + frac/2^ACC_W.
- Converts each instantaneous ratio to the divider's 8-bit p word and 3-bit stage-extension code e.

Parameters:
- ACC_W, 16, accumulator width; fractional resolution 2^-ACC_W.

Ports:
- in_clk  input  1  clock; driven by the divider out_clk; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  1 = modulation on; 0 = accumulators hold and the ratio is n_int exactly.
- n_int  input  9  integer part of the ratio, 2..511.
- frac  input  ACC_W  fractional part, unsigned, /2^ACC_W.
- p  output  8  divider program bits (registered).
- e  output  3  divider extension code (registered).
- sat  output  1  1 = the current ratio was clamped (registered).

Behaviour:
- Reset (async, rst=1): s1, s2, s3 = 0; c2_d, c3_d, c3_dd = 0; p = 8'h00; e = 3'd7 (N=256); sat = 0. Outputs are stable from rst assertion until the first rising edge after deassertion.
- Per rising edge with en=1, evaluated combinationally from current register state, then all registers update together:
  - {c1,a1} = s1 + frac; {c2,a2} = s2 + a1; {c3,a3} = s3 + a2 (each ACC_W+1 bits, carry = MSB).
  - s1<=a1, s2<=a2, s3<=a3; c2_d<=c2; c3_dd<=c3_d; c3_d<=c3.
  - y = c1 + c2 - c2_d + c3 - 2*c3_d + c3_dd, signed, range -3..+4 (4-bit signed is sufficient).
- en=0: s*, c*_d hold their values; y forced to 0.
  - Re-enabling resumes from the held state; no reset of the accumulators.
- Ratio: N = n_int + y, computed in 11-bit signed.
  - N<2 -> N=2, sat=1. N>511 -> N=511, sat=1. Otherwise sat=0.
- Encoding: m = index of the MSB of N (1..8).
  - e = m-1.
  - p[i] = N[i] for i<m; p[i] = 0 for i>=m (for m=8, p = N[7:0]).
  - The divider ratio is 2^m + p.
- Latency: p/e/sat at edge k reflect n_int/frac sampled at edge k (one register stage); the divider loads them at its next modulus cycle.
- frac or n_int changes take effect at the next edge; no glitch filtering is required.
- frac=0: all carries are 0 after the delay registers flush (≤2 edges from a zero state), so N=n_int.
- Reset mid-operation: immediate return to reset values; any partially accumulated phase is discarded.
- Carries wrap modulo 2^ACC_W; no accumulator saturation.

Test Plan:
- Reset: hold rst=1 and toggle in_clk -> p=0x00, e=7, sat=0 throughout. Release with en=1, n_int=300, frac=0 -> after 1 edge p=0x2C, e=7, sat=0, constant thereafter.
- Encoding sweep, en=0:
  - n_int=5 -> p=0x01, e=1.
  - n_int=2 -> p=0x00, e=0.
  - n_int=511 -> p=0xFF, e=7.
  - n_int=128 -> p=0x00, e=6.
- Fractional average: n_int=300, frac=0x8000 (ACC_W=16), 4096 edges.
  - Every decoded N is in 297..304.
  - Sum of N over edges 17..4112 = 300.5*4096 ±4.
  - sat never asserted.
- Clamping:
  - n_int=2, frac=0x4000 -> N never <2; sat=1 exactly on the edges where the raw y<0.
  - n_int=511, frac=0xC000 -> N never >511; sat pulses accordingly.
- Hold/resume: run frac=0x1234 for 100 edges, drop en for 50 edges -> N=n_int, accumulators frozen. Raise en -> the sequence continues identically to an uninterrupted golden-model run with the 50 edges removed.
- Async reset mid-run: assert rst between clock edges -> outputs go to p=0x00, e=7, sat=0 without a clock edge. After release, the output sequence matches a fresh golden model from zero state.

Source files
------------

// File: rtl/sdm_ratio_modulator.sv
// sdm_ratio_modulator
// MASH 1-1-1 delta-sigma modulator and ratio encoder. The modulator drives the
// p/e program inputs of a Vaucher 2/3-cell integer divider. It is clocked by the
// divider output, so it produces one modulus per divider period. The average
// ratio is n_int + frac/2^ACC_W.
module sdm_ratio_modulator #(
   parameter int ACC_W = 16
) (
   input  logic             in_clk,
   input  logic             rst,
   input  logic             en,
   input  logic [8:0]       n_int,
   input  logic [ACC_W-1:0] frac,
   output logic [7:0]       p,
   output logic [2:0]       e,
   output logic             sat
);

   // Accumulator phases and carry delay line
   logic [ACC_W-1:0] s1, s2, s3;
   logic             c2_d, c3_d, c3_dd;

   // Combinational evaluation from the current register state
   logic [ACC_W:0]      sum1_p0, sum2_p0, sum3_p0;
   logic                c1_p0, c2_p0, c3_p0;
   logic signed [3:0]   y_p0;
   logic signed [10:0]  n_raw_p0;
   logic [9:0]          clamp_p0;
   logic [10:0]         enc_p0;

   // Limits the instantaneous ratio to the divider range 2..511.
   // Returns {sat, N[8:0]}.
   function automatic logic [9:0] clamp_ratio(input logic signed [10:0] n_raw);
      logic [9:0] r;
      if (n_raw < 11'sd2)
         r = {1'b1, 9'd2};
      else if (n_raw > 11'sd511)
         r = {1'b1, 9'd511};
      else
         r = {1'b0, n_raw[8:0]};
      return r;
   endfunction

   // Splits N into the divider word. m is the MSB index of N, and e = m-1.
   // p keeps the bits below the MSB, so N = 2^m + p. Returns {e, p}.
   function automatic logic [10:0] encode_ratio(input logic [8:0] n);
      int         m;
      logic [7:0] pw;
      m = 1;
      for (int i = 1; i < 9; i++)
         if (n[i]) m = i;
      pw = '0;
      for (int i = 0; i < 8; i++)
         if (i < m) pw[i] = n[i];
      return {3'(m - 1), pw};
   endfunction

   // Cascaded accumulators, the noise-shaping combiner, the ratio clamp and the encoding
   always_comb begin
      sum1_p0  = {1'b0, s1} + {1'b0, frac};
      sum2_p0  = {1'b0, s2} + {1'b0, sum1_p0[ACC_W-1:0]};
      sum3_p0  = {1'b0, s3} + {1'b0, sum2_p0[ACC_W-1:0]};
      c1_p0    = sum1_p0[ACC_W];
      c2_p0    = sum2_p0[ACC_W];
      c3_p0    = sum3_p0[ACC_W];
      y_p0     = 4'sd0;
      if (en)
         y_p0 = $signed({3'b000, c1_p0}) + $signed({3'b000, c2_p0})
              - $signed({3'b000, c2_d})  + $signed({3'b000, c3_p0})
              - $signed({2'b00, c3_d, 1'b0}) + $signed({3'b000, c3_dd});
      n_raw_p0 = $signed({2'b00, n_int}) + $signed({{7{y_p0[3]}}, y_p0});
      clamp_p0 = clamp_ratio(n_raw_p0);
      enc_p0   = encode_ratio(clamp_p0[8:0]);
   end

   // Advance the accumulators and the carry delay line only while modulation is enabled
   always_ff @(posedge in_clk or posedge rst) begin
      if (rst) begin
         s1    <= '0;
         s2    <= '0;
         s3    <= '0;
         c2_d  <= 1'b0;
         c3_d  <= 1'b0;
         c3_dd <= 1'b0;
      end else if (en) begin
         s1    <= sum1_p0[ACC_W-1:0];
         s2    <= sum2_p0[ACC_W-1:0];
         s3    <= sum3_p0[ACC_W-1:0];
         c2_d  <= c2_p0;
         c3_dd <= c3_d;
         c3_d  <= c3_p0;
      end
   end

   // ---- stage p0 -> output register ----
   // Register the divider program word. Reset selects N = 256.
   always_ff @(posedge in_clk or posedge rst) begin
      if (rst) begin
         p   <= 8'h00;
         e   <= 3'd7;
         sat <= 1'b0;
      end else begin
         p   <= enc_p0[7:0];
         e   <= enc_p0[10:8];
         sat <= clamp_p0[9];
      end
   end

endmodule

// File: tb/tb_sdm_ratio_modulator.sv
// Testbench for sdm_ratio_modulator. It uses a scoreboard driven by an
// independent integer golden model of the MASH 1-1-1 modulator.
`timescale 1ns/1ps
module tb_sdm_ratio_modulator;

   localparam int ACC_W = 16;
   localparam int MODV  = 1 << ACC_W;

   logic             in_clk = 1'b0;
   logic             rst    = 1'b1;
   logic             en     = 1'b0;
   logic [8:0]       n_int  = 9'd2;
   logic [ACC_W-1:0] frac   = '0;
   logic [7:0]       p;
   logic [2:0]       e;
   logic             sat;

   sdm_ratio_modulator #(.ACC_W(ACC_W)) dut (
      .in_clk (in_clk),
      .rst    (rst),
      .en     (en),
      .n_int  (n_int),
      .frac   (frac),
      .p      (p),
      .e      (e),
      .sat    (sat)
   );

   always #5 in_clk = ~in_clk;

   int total = 0;
   int bad   = 0;

   typedef struct { int p; int e; int sat; } exp_t;
   exp_t sb[$];

   // Golden model state
   int m_s1, m_s2, m_s3, m_c2d, m_c3d, m_c3dd;
   int last_n;   // N decoded from the DUT outputs of the last step
   int last_sat;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
      m_c2d = 0; m_c3d = 0; m_c3dd = 0;
   endtask

   // One edge of the golden model. It pushes the expected p/e/sat values.
   task automatic model_push(input int en_i, input int n_i, input int f_i);
      int t1, t2, t3, a1, a2, a3, c1, c2, c3, y, nn, s, m;
      exp_t x;
      t1 = m_s1 + f_i;  c1 = (t1 >= MODV); a1 = t1 % MODV;
      t2 = m_s2 + a1;   c2 = (t2 >= MODV); a2 = t2 % MODV;
      t3 = m_s3 + a2;   c3 = (t3 >= MODV); a3 = t3 % MODV;
      y = 0;
      if (en_i != 0) begin
         y = c1 + c2 - m_c2d + c3 - 2 * m_c3d + m_c3dd;
         m_s1 = a1; m_s2 = a2; m_s3 = a3;
         m_c3dd = m_c3d; m_c3d = c3; m_c2d = c2;
      end
      nn = n_i + y;
      s = 0;
      if (nn < 2)   begin nn = 2;   s = 1; end
      if (nn > 511) begin nn = 511; s = 1; end
      m = 8;
      while ((1 << m) > nn) m--;
      x.p = nn - (1 << m);
      x.e = m - 1;
      x.sat = s;
      sb.push_back(x);
   endtask

   // Drive one edge's inputs, clock it, then compare against the scoreboard.
   task automatic step(input int en_i, input int n_i, input int f_i);
      exp_t x;
      en = (en_i != 0);
      n_int = 9'(n_i);
      frac = ACC_W'(f_i);
      model_push(en_i, n_i, f_i);
      @(posedge in_clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         x = sb.pop_front();
         check("pes", {52'd0, p, 1'b0, e, sat}, {52'd0, 8'(x.p), 1'b0, 3'(x.e), 1'(x.sat)});
      end
      last_n = (1 << (int'(e) + 1)) + int'(p);
      last_sat = int'(sat);
   endtask

   task automatic do_reset();
      @(posedge in_clk);
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      @(posedge in_clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint sum;
      int nmin, nmax, satcnt;
      model_reset();

      // The outputs must stay at their reset values while reset is held and the clock toggles.
      for (int i = 0; i < 3; i++) begin
         @(posedge in_clk);
         #1;
         check("rst_hold", {p, e, sat}, {8'h00, 3'd7, 1'b0});
      end
      rst = 1'b0;
      step(1, 300, 0);
      check("rel_p", p, 8'h2C);
      check("rel_e", e, 3'd7);
      for (int i = 0; i < 5; i++) step(1, 300, 0);
      check("rel_const", {p, e, sat}, {8'h2C, 3'd7, 1'b0});

      // Encoding sweep with modulation off
      step(0, 5, 0);   check("enc5",   {p, e}, {8'h01, 3'd1});
      step(0, 2, 0);   check("enc2",   {p, e}, {8'h00, 3'd0});
      step(0, 511, 0); check("enc511", {p, e}, {8'hFF, 3'd7});
      step(0, 128, 0); check("enc128", {p, e}, {8'h00, 3'd6});

      // Fractional average of 300.5
      do_reset();
      sum = 0; nmin = 1000; nmax = 0; satcnt = 0;
      for (int k = 1; k <= 4112; k++) begin
         step(1, 300, 16'h8000);
         if (last_n < nmin) nmin = last_n;
         if (last_n > nmax) nmax = last_n;
         satcnt += last_sat;
         if (k >= 17) sum += last_n;
      end
      check("frac_min", (nmin >= 297), 1);
      check("frac_max", (nmax <= 304), 1);
      check("frac_nosat", satcnt, 0);
      check("frac_sum", ((sum >= 1230844) && (sum <= 1230852)), 1);

      // Clamping at the low end
      do_reset();
      nmin = 1000;
      for (int k = 0; k < 300; k++) begin
         step(1, 2, 16'h4000);
         if (last_n < nmin) nmin = last_n;
      end
      check("clamp_lo", (nmin >= 2), 1);

      // Clamping at the high end
      nmax = 0;
      for (int k = 0; k < 300; k++) begin
         step(1, 511, 16'hC000);
         if (last_n > nmax) nmax = last_n;
      end
      check("clamp_hi", (nmax <= 511), 1);

      // Hold, then resume. The model freezes its state exactly like the DUT accumulators.
      do_reset();
      for (int k = 0; k < 100; k++) step(1, 200, 16'h1234);
      for (int k = 0; k < 50; k++) step(0, 200, 16'h1234);
      check("hold_n", last_n, 200);
      for (int k = 0; k < 100; k++) step(1, 200, 16'h1234);

      // Asynchronous reset between clock edges
      #3;
      rst = 1'b1;
      #1;
      check("arst", {p, e, sat}, {8'h00, 3'd7, 1'b0});
      model_reset();
      @(posedge in_clk);
      #1;
      check("arst_hold", {p, e, sat}, {8'h00, 3'd7, 1'b0});
      rst = 1'b0;
      for (int k = 0; k < 100; k++) step(1, 200, 16'h1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
